// File: rtl/cfg_stream_pkg.sv
// Shared constants, widths and FSM state type for the configuration stream controller.
package cfg_stream_pkg;

  localparam int unsigned DEF_ADDR_W = 10;
  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned CNT_W      = 16;

  localparam logic [7:0] CMD_WRITE = 8'hA5;
  localparam logic [7:0] CMD_END   = 8'h5A;

  typedef enum logic [2:0] {
    ST_CMD,
    ST_TILE,
    ST_ADDR_HI,
    ST_ADDR_LO,
    ST_LEN,
    ST_DATA,
    ST_DONE,
    ST_ERROR
  } cfg_state_e;

  // DONE and ERROR only leave on reset.
  function automatic logic is_terminal(input cfg_state_e s);
    return (s == ST_DONE) || (s == ST_ERROR);
  endfunction

endpackage

// File: rtl/cfg_write_strobe_gen.sv
// Registers one loader write per request: one-hot tile strobe, shared address/data, saturating count.
module cfg_write_strobe_gen
  import cfg_stream_pkg::*;
#(
  parameter int unsigned NB_TILES = 4,
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned IDX_W    = 2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                wr_en_i,
  input  logic [IDX_W-1:0]    wr_idx_i,
  input  logic [ADDR_W-1:0]   wr_addr_i,
  input  logic [DATA_W-1:0]   wr_data_i,
  output logic [NB_TILES-1:0] select_tile_o,
  output logic [ADDR_W-1:0]   address_tile_o,
  output logic [DATA_W-1:0]   data_tile_o,
  output logic [CNT_W-1:0]    write_count_o
);

  logic [NB_TILES-1:0] select_d, select_q;
  logic [ADDR_W-1:0]   addr_d, addr_q;
  logic [DATA_W-1:0]   data_d, data_q;
  logic [CNT_W-1:0]    count_d, count_q;

  // Decode the strobe (only indices below NB_TILES can ever match) and hold address/data between writes.
  always_comb begin
    select_d = '0;
    addr_d   = addr_q;
    data_d   = data_q;
    count_d  = count_q;
    for (int unsigned i = 0; i < NB_TILES; i++) begin
      if (wr_en_i && (32'(wr_idx_i) == i)) begin
        select_d[i] = 1'b1;
      end
    end
    if (wr_en_i) begin
      addr_d = wr_addr_i;
      data_d = wr_data_i;
      if (count_q != '1) begin
        count_d = count_q + CNT_W'(1);
      end
    end
  end

  // Output registers; synchronous reset drops any pending strobe.
  always_ff @(posedge clock) begin
    if (reset) begin
      select_q <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      count_q  <= '0;
    end else begin
      select_q <= select_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      count_q  <= count_d;
    end
  end

  assign select_tile_o  = select_q;
  assign address_tile_o = addr_q;
  assign data_tile_o    = data_q;
  assign write_count_o  = count_q;

endmodule

// File: rtl/config_stream_controller.sv
// Parses the byte-wide configuration bitstream and issues tile loader writes.
module config_stream_controller
  import cfg_stream_pkg::*;
#(
  parameter int unsigned NB_TILES = 4,
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned DATA_W   = DEF_DATA_W
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [DATA_W-1:0]   in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [NB_TILES-1:0] select_tile,
  output logic [ADDR_W-1:0]   address_tile,
  output logic [DATA_W-1:0]   data_tile,
  output logic                cfg_done,
  output logic                cfg_error,
  output logic [CNT_W-1:0]    write_count
);

  localparam int unsigned IDX_W = (NB_TILES > 1) ? $clog2(NB_TILES) : 1;

  cfg_state_e         state_d, state_q;
  logic [IDX_W-1:0]   idx_d, idx_q;
  logic [ADDR_W-1:0]  addr_d, addr_q;
  logic [DATA_W-1:0]  len_d, len_q;
  logic               ready_d, ready_q;
  logic               done_d, done_q;
  logic               error_d, error_q;
  logic               accept_c;
  logic               wr_en_c;

  assign accept_c = in_valid && ready_q;

  // Next-state and frame field capture; a write request is raised for every accepted data byte.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    len_d   = len_q;
    wr_en_c = 1'b0;
    if (accept_c) begin
      unique case (state_q)
        ST_CMD: begin
          if (in_data == DATA_W'(CMD_WRITE)) begin
            state_d = ST_TILE;
          end else if (in_data == DATA_W'(CMD_END)) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_ERROR;
          end
        end
        ST_TILE: begin
          if (32'(in_data) >= NB_TILES) begin
            state_d = ST_ERROR;
          end else begin
            idx_d   = IDX_W'(in_data);
            state_d = ST_ADDR_HI;
          end
        end
        ST_ADDR_HI: begin
          // Only the low ADDR_W-DATA_W bits survive the shift into the upper address field.
          addr_d  = ADDR_W'(in_data) << DATA_W;
          state_d = ST_ADDR_LO;
        end
        ST_ADDR_LO: begin
          addr_d  = addr_q | ADDR_W'(in_data);
          state_d = ST_LEN;
        end
        ST_LEN: begin
          if (in_data == '0) begin
            state_d = ST_CMD;
          end else begin
            len_d   = in_data;
            state_d = ST_DATA;
          end
        end
        ST_DATA: begin
          wr_en_c = 1'b1;
          addr_d  = addr_q + ADDR_W'(1);
          len_d   = len_q - DATA_W'(1);
          if (len_q == DATA_W'(1)) begin
            state_d = ST_CMD;
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
    ready_d = !is_terminal(state_d);
    done_d  = (state_d == ST_DONE);
    error_d = (state_d == ST_ERROR);
  end

  // State and parser registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_CMD;
      idx_q   <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      error_q <= error_d;
    end
  end

  cfg_write_strobe_gen #(
    .NB_TILES (NB_TILES),
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .IDX_W    (IDX_W)
  ) u_strobe (
    .clock          (clock),
    .reset          (reset),
    .wr_en_i        (wr_en_c),
    .wr_idx_i       (idx_q),
    .wr_addr_i      (addr_q),
    .wr_data_i      (in_data),
    .select_tile_o  (select_tile),
    .address_tile_o (address_tile),
    .data_tile_o    (data_tile),
    .write_count_o  (write_count)
  );

  assign in_ready  = ready_q;
  assign cfg_done  = done_q;
  assign cfg_error = error_q;

endmodule

// File: tb/tb_config_stream_controller.sv
// Directed self-checking bench for config_stream_controller.
module tb_config_stream_controller;

  typedef logic [7:0] byte_q_t[$];

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  select_tile;
  logic [9:0]  address_tile;
  logic [7:0]  data_tile;
  logic        cfg_done;
  logic        cfg_error;
  logic [15:0] write_count;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int strobe_cnt = 0;
  bit log_en = 1'b1;
  bit multi_hot = 1'b0;
  logic [3:0] log_sel[$];
  logic [9:0] log_addr[$];
  logic [7:0] log_data[$];
  int         log_cyc[$];

  config_stream_controller dut (
    .clock        (clock),
    .reset        (reset),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .select_tile  (select_tile),
    .address_tile (address_tile),
    .data_tile    (data_tile),
    .cfg_done     (cfg_done),
    .cfg_error    (cfg_error),
    .write_count  (write_count)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Record every strobe cycle seen on the loader port.
  always @(negedge clock) begin
    if (select_tile != 4'b0000) begin
      strobe_cnt++;
      if ($countones(select_tile) != 1) multi_hot = 1'b1;
      if (log_en) begin
        log_sel.push_back(select_tile);
        log_addr.push_back(address_tile);
        log_data.push_back(data_tile);
        log_cyc.push_back(cyc);
      end
    end
  end

  task automatic clear_log();
    log_sel.delete(); log_addr.delete(); log_data.delete(); log_cyc.delete();
    strobe_cnt = 0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1; in_valid = 1'b0; in_data = '0;
    @(negedge clock);
    reset = 1'b0;
    clear_log();
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(negedge clock);
  endtask

  // Offer one byte (called at a negedge); returns at the negedge after it was taken.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    in_data = b; in_valid = 1'b1;
    while (!in_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    if (!in_ready) begin
      checks++; failures++;
      $display("FAIL send_timeout byte=%02h got=in_ready 0 exp=in_ready 1", b);
    end else begin
      @(negedge clock);
    end
  endtask

  task automatic send_seq(input byte_q_t bs, input bit gaps);
    int gap_pat[5] = '{1, 0, 2, 0, 3};
    foreach (bs[i]) begin
      if (gaps && gap_pat[i % 5] != 0) idle(gap_pat[i % 5]);
      send_byte(bs[i]);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL rst_in_ready got=%b exp=0", in_ready); end
    checks++; if (select_tile !== 4'b0000) begin failures++; $display("FAIL rst_select got=%b exp=0000", select_tile); end
    checks++; if (address_tile !== 10'h000 || data_tile !== 8'h00) begin failures++; $display("FAIL rst_addr_data got=%03h/%02h exp=000/00", address_tile, data_tile); end
    checks++; if (cfg_done !== 1'b0 || cfg_error !== 1'b0) begin failures++; $display("FAIL rst_flags got=%b%b exp=00", cfg_done, cfg_error); end
    checks++; if (write_count !== 16'h0000) begin failures++; $display("FAIL rst_count got=%0h exp=0", write_count); end
    @(negedge clock);
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_ready_after got=%b exp=1", in_ready); end
  endtask

  task automatic test_back_to_back();
    byte_q_t bs = '{8'hA5, 8'h01, 8'h00, 8'h10, 8'h03, 8'h11, 8'h22, 8'h33};
    logic [9:0] ea[3] = '{10'h010, 10'h011, 10'h012};
    logic [7:0] ed[3] = '{8'h11, 8'h22, 8'h33};
    do_reset();
    idle(1);
    send_seq(bs, 1'b0);
    idle(3);
    checks++; if (log_sel.size() !== 3) begin failures++; $display("FAIL b2b_nwrites got=%0d exp=3", log_sel.size()); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= log_sel.size()) begin failures++; $display("FAIL b2b_write%0d got=none exp=present", i); end
      else if (log_sel[i] !== 4'b0010 || log_addr[i] !== ea[i] || log_data[i] !== ed[i]) begin
        failures++;
        $display("FAIL b2b_write%0d got=sel %b addr %03h data %02h exp=sel 0010 addr %03h data %02h",
                 i, log_sel[i], log_addr[i], log_data[i], ea[i], ed[i]);
      end
    end
    checks++;
    if (log_cyc.size() == 3 && (log_cyc[1] != log_cyc[0] + 1 || log_cyc[2] != log_cyc[1] + 1)) begin
      failures++; $display("FAIL b2b_consecutive got=%0d,%0d,%0d exp=consecutive", log_cyc[0], log_cyc[1], log_cyc[2]);
    end
    checks++; if (write_count !== 16'd3) begin failures++; $display("FAIL b2b_count got=%0d exp=3", write_count); end
    checks++; if (select_tile !== 4'b0000 || address_tile !== 10'h012 || data_tile !== 8'h33) begin
      failures++; $display("FAIL b2b_hold got=%b/%03h/%02h exp=0000/012/33", select_tile, address_tile, data_tile);
    end
  endtask

  task automatic test_gaps_wrap();
    byte_q_t bs = '{8'hA5, 8'h00, 8'h03, 8'hFE, 8'h04, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    logic [9:0] ea[4] = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
    logic [7:0] ed[4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    do_reset();
    idle(1);
    send_seq(bs, 1'b1);
    idle(3);
    checks++; if (strobe_cnt !== 4) begin failures++; $display("FAIL gap_nstrobes got=%0d exp=4", strobe_cnt); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= log_sel.size()) begin failures++; $display("FAIL gap_write%0d got=none exp=present", i); end
      else if (log_sel[i] !== 4'b0001 || log_addr[i] !== ea[i] || log_data[i] !== ed[i]) begin
        failures++;
        $display("FAIL gap_write%0d got=sel %b addr %03h data %02h exp=sel 0001 addr %03h data %02h",
                 i, log_sel[i], log_addr[i], log_data[i], ea[i], ed[i]);
      end
    end
    checks++; if (write_count !== 16'd4) begin failures++; $display("FAIL gap_count got=%0d exp=4", write_count); end
  endtask

  task automatic test_len0_done();
    byte_q_t bs = '{8'hA5, 8'h02, 8'h00, 8'h00, 8'h00, 8'h5A};
    do_reset();
    idle(1);
    send_seq(bs, 1'b0);
    idle(2);
    checks++; if (strobe_cnt !== 0) begin failures++; $display("FAIL done_nstrobes got=%0d exp=0", strobe_cnt); end
    checks++; if (cfg_done !== 1'b1 || cfg_error !== 1'b0) begin failures++; $display("FAIL done_flags got=%b%b exp=10", cfg_done, cfg_error); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL done_ready got=%b exp=0", in_ready); end
    checks++; if (write_count !== 16'd0) begin failures++; $display("FAIL done_count got=%0d exp=0", write_count); end
  endtask

  task automatic test_bad_tile();
    logic [7:0] junk[6] = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h01, 8'h11};
    do_reset();
    idle(1);
    send_byte(8'hA5);
    send_byte(8'h04);
    idle(2);
    checks++; if (cfg_error !== 1'b1 || in_ready !== 1'b0) begin failures++; $display("FAIL badtile_flag got=err %b rdy %b exp=err 1 rdy 0", cfg_error, in_ready); end
    foreach (junk[i]) begin
      in_data = junk[i]; in_valid = 1'b1;
      @(negedge clock);
    end
    idle(2);
    checks++; if (strobe_cnt !== 0 || write_count !== 16'd0) begin failures++; $display("FAIL badtile_ignored got=%0d/%0d exp=0/0", strobe_cnt, write_count); end
    checks++; if (cfg_error !== 1'b1 || cfg_done !== 1'b0) begin failures++; $display("FAIL badtile_sticky got=err %b done %b exp=err 1 done 0", cfg_error, cfg_done); end
    do_reset();
    checks++; if (cfg_error !== 1'b0) begin failures++; $display("FAIL badtile_clear got=%b exp=0", cfg_error); end
  endtask

  task automatic test_bad_cmd_and_abort();
    byte_q_t hdr = '{8'hA5, 8'h03, 8'h01, 8'h00, 8'h05, 8'h10, 8'h20};
    byte_q_t nxt = '{8'hA5, 8'h01, 8'h00, 8'h20, 8'h01, 8'h5C};
    do_reset();
    idle(1);
    send_byte(8'h77);
    idle(1);
    checks++; if (cfg_error !== 1'b1 || in_ready !== 1'b0) begin failures++; $display("FAIL badcmd got=err %b rdy %b exp=err 1 rdy 0", cfg_error, in_ready); end

    do_reset();
    idle(1);
    send_seq(hdr, 1'b0);
    // Second data byte's strobe is visible now; reset aborts the rest of the frame.
    reset = 1'b1; in_valid = 1'b1; in_data = 8'h30;
    @(negedge clock);
    checks++; if (select_tile !== 4'b0000 || write_count !== 16'd0) begin failures++; $display("FAIL abort_rst got=%b/%0d exp=0000/0", select_tile, write_count); end
    reset = 1'b0; in_valid = 1'b0;
    idle(3);
    checks++; if (strobe_cnt !== 2) begin failures++; $display("FAIL abort_nwrites got=%0d exp=2", strobe_cnt); end
    checks++;
    if (log_sel.size() != 2) begin failures++; $display("FAIL abort_log got=%0d exp=2", log_sel.size()); end
    else if (log_sel[0] !== 4'b1000 || log_addr[0] !== 10'h100 || log_data[0] !== 8'h10 ||
             log_sel[1] !== 4'b1000 || log_addr[1] !== 10'h101 || log_data[1] !== 8'h20) begin
      failures++;
      $display("FAIL abort_log got=%b %03h %02h, %b %03h %02h exp=1000 100 10, 1000 101 20",
               log_sel[0], log_addr[0], log_data[0], log_sel[1], log_addr[1], log_data[1]);
    end
    clear_log();
    send_seq(nxt, 1'b0);
    idle(2);
    checks++;
    if (log_sel.size() != 1) begin failures++; $display("FAIL reparse_n got=%0d exp=1", log_sel.size()); end
    else if (log_sel[0] !== 4'b0010 || log_addr[0] !== 10'h020 || log_data[0] !== 8'h5C) begin
      failures++; $display("FAIL reparse_write got=%b %03h %02h exp=0010 020 5c", log_sel[0], log_addr[0], log_data[0]);
    end
    checks++; if (write_count !== 16'd1 || cfg_error !== 1'b0) begin failures++; $display("FAIL reparse_state got=cnt %0d err %b exp=cnt 1 err 0", write_count, cfg_error); end
  endtask

  task automatic test_saturation();
    byte_q_t big = '{8'hA5, 8'h02, 8'h00, 8'h00, 8'hFF};
    byte_q_t tail = '{8'hA5, 8'h02, 8'h00, 8'h00, 8'h02, 8'h01, 8'h02};
    for (int i = 0; i < 255; i++) big.push_back(8'(i));
    do_reset();
    log_en = 1'b0;
    idle(1);
    for (int f = 0; f < 257; f++) send_seq(big, 1'b0);
    idle(2);
    checks++; if (write_count !== 16'hFFFF || strobe_cnt !== 65535) begin failures++; $display("FAIL sat_reach got=%0h/%0d exp=ffff/65535", write_count, strobe_cnt); end
    send_seq(tail, 1'b0);
    idle(2);
    checks++; if (write_count !== 16'hFFFF || strobe_cnt !== 65537) begin failures++; $display("FAIL sat_hold got=%0h/%0d exp=ffff/65537", write_count, strobe_cnt); end
    log_en = 1'b1;
  endtask

  task automatic test_onehot();
    checks++; if (multi_hot !== 1'b0) begin failures++; $display("FAIL onehot got=multi-hot exp=one-hot"); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_gaps_wrap();
    test_len0_done();
    test_bad_tile();
    test_bad_cmd_and_abort();
    test_saturation();
    test_onehot();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
